// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // Region bases used by the address decode in front of the arbiter.
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory macro signals for the arbiter.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // Requesters plus memory view.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of data grants taken while fetch was waiting.
module mem_arbiter_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MaxVal = 4'(STARVE_MAX);

  logic [3:0] cnt;

  // Clear wins over increment; increment stops at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != MaxVal)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == MaxVal);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one fixed-latency memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

  state_e      state;
  logic [3:0]  lat_cnt;
  logic        owner;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        can_issue;
  logic        at_max;
  logic        grant_d;
  logic        grant_i;
  logic        issue;
  logic        rsp;
  logic [31:0] addr_nxt;
  logic [31:0] wdata_nxt;

  // Issue only when idle or on the last busy cycle; never while in reset.
  always_comb begin
    can_issue = rst && ((state == ST_IDLE) || (lat_cnt == 4'd0));
    grant_d   = can_issue && bus.d_req && !(bus.i_req && at_max);
    grant_i   = can_issue && bus.i_req && !grant_d;
    issue     = grant_d || grant_i;
    rsp       = (state == ST_BUSY) && (lat_cnt == 4'd0);
    addr_nxt  = grant_d ? bus.d_addr : (grant_i ? bus.i_addr : addr_q);
    wdata_nxt = grant_d ? bus.d_wdata : wdata_q;
  end

  // Memory strobes and response routing.
  always_comb begin
    bus.i_gnt     = grant_i;
    bus.d_gnt     = grant_d;
    bus.mem_en    = issue;
    bus.mem_we    = grant_d && bus.d_we;
    bus.mem_addr  = addr_nxt;
    bus.mem_wdata = wdata_nxt;
    bus.mem_wstrb = (grant_d && bus.d_we) ? bus.d_wstrb : 4'b0000;
    bus.i_rvalid  = rsp && (owner == OWNER_IF);
    bus.d_rvalid  = rsp && (owner == OWNER_D);
    bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : 32'd0;
    bus.d_rdata   = (bus.d_rvalid && !we_q) ? bus.mem_rdata : 32'd0;
  end

  // Access sequencer: latch owner on issue, count down the memory latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      lat_cnt <= 4'd0;
      owner   <= OWNER_IF;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (issue) begin
      state   <= ST_BUSY;
      lat_cnt <= LatInit;
      owner   <= grant_d ? OWNER_D : OWNER_IF;
      we_q    <= grant_d && bus.d_we;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end else if (state == ST_BUSY) begin
      if (lat_cnt == 4'd0) begin
        state <= ST_IDLE;
      end else begin
        lat_cnt <= lat_cnt - 4'd1;
      end
    end
  end

  mem_arbiter_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (grant_d && bus.i_req),
    .clr   (grant_i || !bus.i_req),
    .at_max(at_max)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: two arbiters (latency 2 and latency 1) with address-derived memories.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_arbiter_if if_a ();
  mem_arbiter_if if_b ();

  mem_arbiter #(
    .MEM_LAT   (2),
    .STARVE_MAX(4)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(if_a)
  );

  mem_arbiter #(
    .MEM_LAT   (1),
    .STARVE_MAX(4)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0010) return 32'h00A0_0093;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory models: read word appears MEM_LAT cycles after the strobe.
  logic [31:0] pipe_a0, pipe_a1, pipe_b0;
  always @(posedge clk) begin
    pipe_a0 <= if_a.mem_addr;
    pipe_a1 <= pipe_a0;
    pipe_b0 <= if_b.mem_addr;
  end
  assign if_a.mem_rdata = mem_word(pipe_a1);
  assign if_b.mem_rdata = mem_word(pipe_b0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    {if_a.i_req, if_a.d_req, if_a.d_we} = 3'b000;
    {if_b.i_req, if_b.d_req, if_b.d_we} = 3'b000;
    if_a.i_addr = 32'd0; if_a.d_addr = 32'd0; if_a.d_wdata = 32'd0; if_a.d_wstrb = 4'd0;
    if_b.i_addr = 32'd0; if_b.d_addr = 32'd0; if_b.d_wdata = 32'd0; if_b.d_wstrb = 4'd0;
    #2;
    check_eq("rst_i_gnt",    32'(if_a.i_gnt),    32'd0);
    check_eq("rst_d_gnt",    32'(if_a.d_gnt),    32'd0);
    check_eq("rst_mem_en",   32'(if_a.mem_en),   32'd0);
    check_eq("rst_mem_we",   32'(if_a.mem_we),   32'd0);
    check_eq("rst_mem_addr", if_a.mem_addr,      32'd0);
    check_eq("rst_wstrb",    32'(if_a.mem_wstrb), 32'd0);
    check_eq("rst_rvalid",   32'({if_a.i_rvalid, if_a.d_rvalid}), 32'd0);
    check_eq("rst_rdata",    if_a.i_rdata | if_a.d_rdata, 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // Fetch only.
    step();
    if_a.i_req = 1'b1; if_a.i_addr = 32'h0040_0010;
    #1;
    check_eq("f_i_gnt",    32'(if_a.i_gnt),  32'd1);
    check_eq("f_d_gnt",    32'(if_a.d_gnt),  32'd0);
    check_eq("f_mem_en",   32'(if_a.mem_en), 32'd1);
    check_eq("f_mem_we",   32'(if_a.mem_we), 32'd0);
    check_eq("f_mem_addr", if_a.mem_addr,    32'h0040_0010);
    step();
    if_a.i_req = 1'b0;
    #1;
    check_eq("f_c1_rvalid", 32'(if_a.i_rvalid), 32'd0);
    check_eq("f_c1_mem_en", 32'(if_a.mem_en),   32'd0);
    check_eq("f_addr_hold", if_a.mem_addr,      32'h0040_0010);
    step();
    #1;
    check_eq("f_i_rvalid", 32'(if_a.i_rvalid), 32'd1);
    check_eq("f_i_rdata",  if_a.i_rdata,       32'h00A0_0093);
    check_eq("f_d_rvalid", 32'(if_a.d_rvalid), 32'd0);

    // Simultaneous fetch and load: data first, fetch back-to-back.
    step();
    if_a.i_req = 1'b1; if_a.i_addr = 32'h0040_0014;
    if_a.d_req = 1'b1; if_a.d_we = 1'b0; if_a.d_addr = 32'h1001_0004;
    #1;
    check_eq("s_d_gnt",    32'(if_a.d_gnt), 32'd1);
    check_eq("s_i_gnt",    32'(if_a.i_gnt), 32'd0);
    check_eq("s_mem_addr", if_a.mem_addr,   32'h1001_0004);
    step();
    if_a.d_req = 1'b0;
    #1;
    check_eq("s_c1_i_gnt", 32'(if_a.i_gnt),  32'd0);
    check_eq("s_c1_en",    32'(if_a.mem_en), 32'd0);
    step();
    #1;
    check_eq("s_d_rvalid",  32'(if_a.d_rvalid), 32'd1);
    check_eq("s_d_rdata",   if_a.d_rdata,       32'h4A5B_5A5E);
    check_eq("s_i_gnt_b2b", 32'(if_a.i_gnt),    32'd1);
    check_eq("s_b2b_addr",  if_a.mem_addr,      32'h0040_0014);
    check_eq("s_i_rv_early", 32'(if_a.i_rvalid), 32'd0);
    step();
    if_a.i_req = 1'b0;
    step();
    #1;
    check_eq("s_i_rvalid", 32'(if_a.i_rvalid), 32'd1);
    check_eq("s_i_rdata",  if_a.i_rdata,       32'h5A1A_5A4E);
    check_eq("s_d_rv_off", 32'(if_a.d_rvalid), 32'd0);

    // Store.
    step();
    if_a.d_req = 1'b1; if_a.d_we = 1'b1; if_a.d_addr = 32'h1001_0008;
    if_a.d_wdata = 32'hDEAD_BEEF; if_a.d_wstrb = 4'b0011;
    #1;
    check_eq("w_d_gnt",     32'(if_a.d_gnt),     32'd1);
    check_eq("w_mem_we",    32'(if_a.mem_we),    32'd1);
    check_eq("w_mem_wstrb", 32'(if_a.mem_wstrb), 32'h3);
    check_eq("w_mem_wdata", if_a.mem_wdata,      32'hDEAD_BEEF);
    step();
    if_a.d_req = 1'b0; if_a.d_we = 1'b0;
    #1;
    check_eq("w_c1_we",    32'(if_a.mem_we), 32'd0);
    check_eq("w_wd_hold",  if_a.mem_wdata,   32'hDEAD_BEEF);
    step();
    #1;
    check_eq("w_d_rvalid", 32'(if_a.d_rvalid), 32'd1);
    check_eq("w_d_rdata",  if_a.d_rdata,       32'd0);
    check_eq("w_i_rvalid", 32'(if_a.i_rvalid), 32'd0);

    // Starvation: four data grants, then fetch is forced, then data again.
    for (int c = 0; c <= 12; c++) begin
      step();
      if (c == 0) begin
        if_a.i_req = 1'b1; if_a.i_addr = 32'h0040_0020;
        if_a.d_req = 1'b1; if_a.d_we = 1'b0; if_a.d_addr = 32'h1001_0010;
      end
      if (c == 9)  if_a.i_req = 1'b0;
      if (c == 11) if_a.d_req = 1'b0;
      #1;
      if (c <= 11) begin
        check_eq($sformatf("st_d_gnt_c%0d", c), 32'(if_a.d_gnt),
                 32'((c % 2 == 0) && (c != 8)));
        check_eq($sformatf("st_i_gnt_c%0d", c), 32'(if_a.i_gnt), 32'(c == 8));
      end
      if (c == 10) begin
        check_eq("st_i_rvalid", 32'(if_a.i_rvalid), 32'd1);
        check_eq("st_i_rdata",  if_a.i_rdata,       32'h5A1A_5A7A);
        check_eq("st_d_rv_off", 32'(if_a.d_rvalid), 32'd0);
      end
      if (c == 12) begin
        check_eq("st_d_rvalid", 32'(if_a.d_rvalid), 32'd1);
        check_eq("st_d_rdata",  if_a.d_rdata,       32'h4A5B_5A4A);
      end
    end
    step();

    // Reset one cycle after a load grant.
    step();
    if_a.d_req = 1'b1; if_a.d_we = 1'b0; if_a.d_addr = 32'h1001_000C;
    #1;
    check_eq("r_d_gnt", 32'(if_a.d_gnt), 32'd1);
    step();
    if_a.d_req = 1'b0;
    if_a.i_req = 1'b1; if_a.i_addr = 32'h0040_0030;
    rst = 1'b0;
    #1;
    check_eq("r_i_gnt",     32'(if_a.i_gnt),  32'd0);
    check_eq("r_mem_en",    32'(if_a.mem_en), 32'd0);
    check_eq("r_mem_addr",  if_a.mem_addr,    32'd0);
    check_eq("r_mem_wdata", if_a.mem_wdata,   32'd0);
    step();
    #1;
    check_eq("r_no_rvalid", 32'(if_a.d_rvalid), 32'd0);
    check_eq("r_d_rdata",   if_a.d_rdata,       32'd0);
    step();
    rst = 1'b1;
    #1;
    check_eq("r_fresh_gnt",  32'(if_a.i_gnt), 32'd1);
    check_eq("r_fresh_addr", if_a.mem_addr,   32'h0040_0030);
    step();
    if_a.i_req = 1'b0;
    step();
    #1;
    check_eq("r_i_rvalid", 32'(if_a.i_rvalid), 32'd1);
    check_eq("r_i_rdata",  if_a.i_rdata,       32'h5A1A_5A6A);

    // Latency 1: back-to-back loads every cycle.
    step();
    if_b.d_req = 1'b1; if_b.d_we = 1'b0; if_b.d_addr = 32'h1001_0040;
    #1;
    check_eq("l1_gnt0", 32'(if_b.d_gnt),    32'd1);
    check_eq("l1_rv0",  32'(if_b.d_rvalid), 32'd0);
    step();
    if_b.d_addr = 32'h1001_0044;
    #1;
    check_eq("l1_gnt1",   32'(if_b.d_gnt),    32'd1);
    check_eq("l1_rv1",    32'(if_b.d_rvalid), 32'd1);
    check_eq("l1_rdata1", if_b.d_rdata,       32'h4A5B_5A1A);
    step();
    if_b.d_addr = 32'h1001_0048;
    #1;
    check_eq("l1_gnt2",   32'(if_b.d_gnt),    32'd1);
    check_eq("l1_rv2",    32'(if_b.d_rvalid), 32'd1);
    check_eq("l1_rdata2", if_b.d_rdata,       32'h4A5B_5A1E);
    step();
    if_b.d_req = 1'b0;
    #1;
    check_eq("l1_gnt3",   32'(if_b.d_gnt),    32'd0);
    check_eq("l1_rv3",    32'(if_b.d_rvalid), 32'd1);
    check_eq("l1_rdata3", if_b.d_rdata,       32'h4A5B_5A12);
    step();
    #1;
    check_eq("l1_rv4", 32'(if_b.d_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
